// File: rtl/disc_frame_feeder.sv
// disc_frame_feeder
// Producer side of the discriminator scoring interface. Gathers a serial
// stream of Q8.8 pixels into a flat frame bus, fires a one-cycle start,
// waits for a fresh done edge (with a watchdog), and hands the captured
// score/decision back on a valid/ready result port.
module disc_frame_feeder #(
    parameter int N_ELEM   = 256,
    parameter int DATA_W   = 16,
    parameter bit CLAMP_EN = 1'b1,
    parameter int TIMEOUT  = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic [DATA_W*N_ELEM-1:0]   flat_input,
    output logic                       disc_start,
    input  logic                       disc_done,
    input  logic [15:0]                disc_score,
    input  logic                       disc_real,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [15:0]                res_score,
    output logic                       res_real,
    output logic                       busy,
    output logic                       timeout_err,
    output logic [15:0]                frame_cnt
);

    localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    // Q8.8 +1.0 / -1.0
    localparam logic signed [DATA_W-1:0] POS_ONE = DATA_W'(256);
    localparam logic signed [DATA_W-1:0] NEG_ONE = DATA_W'(-256);

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_FIRE   = 2'd1,
        S_WAIT   = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WD_W-1:0]    wd_q;
    logic               in_ready_q;
    logic               start_q;
    logic               done_q;
    logic               res_valid_q;
    logic [15:0]        res_score_q;
    logic               res_real_q;
    logic               busy_q;
    logic               tmo_q;
    logic [15:0]        cnt_q;

    logic [DATA_W-1:0]  pix_d;
    logic               accept;
    logic               done_rise;

    // Saturate a signed Q8.8 pixel to [-1.0, +1.0] when clamping is enabled.
    function automatic logic [DATA_W-1:0] clamp_pix(input logic [DATA_W-1:0] v);
        logic signed [DATA_W-1:0] s;
        logic [DATA_W-1:0]        r;
        s = $signed(v);
        r = v;
        if (CLAMP_EN) begin
            if (s > POS_ONE)      r = POS_ONE;
            else if (s < NEG_ONE) r = NEG_ONE;
        end
        return r;
    endfunction

    // in_ready_q is only ever high in FILL, so it alone qualifies acceptance.
    assign pix_d     = clamp_pix(in_data);
    assign accept    = in_valid & in_ready_q;
    // Only a fresh edge counts: a done left high from an earlier job is stale.
    assign done_rise = disc_done & ~done_q;

    // One register per frame element; only the addressed slot updates, the
    // rest keep the previous frame's contents until overwritten.
    for (genvar g = 0; g < N_ELEM; g++) begin : g_elem
        logic [DATA_W-1:0] elem_q;

        // Element capture on accepted pixel addressed to this slot.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                elem_q <= '0;
            else if (accept && (idx_q == IDX_W'(g)))
                elem_q <= pix_d;
        end

        assign flat_input[g*DATA_W +: DATA_W] = elem_q;
    end

    // Frame sequencer: FILL -> FIRE -> WAIT -> REPORT/FILL, registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FILL;
            idx_q       <= '0;
            wd_q        <= '0;
            in_ready_q  <= 1'b1;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_score_q <= '0;
            res_real_q  <= 1'b0;
            busy_q      <= 1'b0;
            tmo_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            done_q  <= disc_done;
            start_q <= 1'b0;
            case (state_q)
                S_FILL: begin
                    if (accept) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q      <= '0;
                            state_q    <= S_FIRE;
                            in_ready_q <= 1'b0;
                            start_q    <= 1'b1;
                            busy_q     <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_FIRE: begin
                    state_q <= S_WAIT;
                    wd_q    <= '0;
                end
                S_WAIT: begin
                    if (done_rise) begin
                        res_score_q <= disc_score;
                        res_real_q  <= disc_real;
                        res_valid_q <= 1'b1;
                        cnt_q       <= cnt_q + 1'b1;
                        state_q     <= S_REPORT;
                    end else if (wd_q == WD_LAST) begin
                        // Abort after TIMEOUT idle WAIT cycles; frame is dropped.
                        tmo_q      <= 1'b1;
                        state_q    <= S_FILL;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_REPORT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= S_FILL;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= S_FILL;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign disc_start  = start_q;
    assign res_valid   = res_valid_q;
    assign res_score   = res_score_q;
    assign res_real    = res_real_q;
    assign busy        = busy_q;
    assign timeout_err = tmo_q;
    assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_disc_frame_feeder.sv
// Bench for disc_frame_feeder: randomized frames checked against a
// frame-level reference model (element array, clamp rule, frame counter).
module tb_disc_frame_feeder;

    localparam int N   = 256;
    localparam int DW  = 16;
    localparam int TMO = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     in_data = '0;
    logic [DW*N-1:0]   flat_input;
    logic              disc_start;
    logic              disc_done = 1'b0;
    logic [15:0]       disc_score = '0;
    logic              disc_real = 1'b0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [15:0]       res_score;
    logic              res_real;
    logic              busy;
    logic              timeout_err;
    logic [15:0]       frame_cnt;

    disc_frame_feeder #(
        .N_ELEM(N), .DATA_W(DW), .CLAMP_EN(1'b1), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .flat_input(flat_input),
        .disc_start(disc_start), .disc_done(disc_done),
        .disc_score(disc_score), .disc_real(disc_real),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_score(res_score), .res_real(res_real),
        .busy(busy), .timeout_err(timeout_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int start_cnt = 0;

    // Reference model state
    logic [15:0] pix [N];
    logic [15:0] exp_elem [N];
    int          mdl_idx = 0;
    int          exp_cnt = 0;

    always @(posedge clk) if (disc_start === 1'b1) start_cnt <= start_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [15:0] clampf(input logic [15:0] v);
        int s;
        s = int'($signed(v));
        if (s > 256)       return 16'h0100;
        else if (s < -256) return 16'hFF00;
        else               return v;
    endfunction

    // Index of first frame element differing from the model, -1 if none.
    function automatic int first_bad();
        for (int i = 0; i < N; i++)
            if (flat_input[i*DW +: DW] !== exp_elem[i]) return i;
        return -1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) exp_elem[i] = '0;
        mdl_idx = 0;
        exp_cnt = 0;
    endfunction

    // Stream pix[0..n-1]; returns at the negedge one cycle after the last accept.
    task automatic feed(input int n, input bit gaps, output bit frame_done);
        int sent;
        int guard;
        sent = 0;
        guard = 0;
        frame_done = 1'b0;
        while (sent < n && guard < 4000) begin
            @(negedge clk);
            guard++;
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = pix[sent];
                if (in_ready === 1'b1) begin
                    exp_elem[mdl_idx] = clampf(pix[sent]);
                    mdl_idx = (mdl_idx + 1) % N;
                    if (mdl_idx == 0) frame_done = 1'b1;
                    sent++;
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (sent < n) begin
            fails++;
            $display("FAIL feed_stall: sent %0d required %0d", sent, n);
        end
    endtask

    task automatic rand_frame();
        for (int i = 0; i < N; i++) pix[i] = 16'($urandom);
    endtask

    // Raise done with a result after dly negedges.
    task automatic disc_respond(input int dly, input logic [15:0] sc, input logic rl);
        repeat (dly) @(negedge clk);
        disc_done  = 1'b1;
        disc_score = sc;
        disc_real  = rl;
    endtask

    task automatic ack_result();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        disc_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || disc_start !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: in_ready=%b start=%b res_valid=%b busy=%b required 1 0 0 0",
                     in_ready, disc_start, res_valid, busy);
        end
        tests++;
        if (flat_input !== '0 || frame_cnt !== 16'd0 || timeout_err !== 1'b0 || res_score !== 16'd0) begin
            fails++;
            $display("FAIL reset_data: flat_zero=%b cnt=%h tmo=%b score=%h required 1 0000 0 0000",
                     flat_input == '0, frame_cnt, timeout_err, res_score);
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_ramp();
        bit fr;
        int s0;
        int b;
        s0 = start_cnt;
        for (int i = 0; i < N; i++) pix[i] = 16'(i);
        feed(N, 1'b0, fr);
        tests++;
        if (disc_start !== 1'b1 || !fr) begin
            fails++;
            $display("FAIL ramp_start_latency: disc_start=%b required 1", disc_start);
        end
        disc_respond(4, 16'h0180, 1'b1);
        tests++;
        if (res_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL ramp_wait: res_valid=%b in_ready=%b busy=%b required 0 0 1",
                     res_valid, in_ready, busy);
        end
        @(negedge clk);
        exp_cnt++;
        tests++;
        if (res_valid !== 1'b1 || res_score !== 16'h0180 || res_real !== 1'b1) begin
            fails++;
            $display("FAIL ramp_result: valid=%b score=%h real=%b required 1 0180 1",
                     res_valid, res_score, res_real);
        end
        tests++;
        if (frame_cnt !== 16'(exp_cnt) || flat_input[5*DW +: DW] !== 16'h0005) begin
            fails++;
            $display("FAIL ramp_cnt_elem5: cnt=%0d elem5=%h required %0d 0005",
                     frame_cnt, flat_input[5*DW +: DW], exp_cnt);
        end
        b = first_bad();
        tests++;
        if (b != -1) begin
            fails++;
            $display("FAIL ramp_frame: elem %0d is %h required %h", b, flat_input[b*DW +: DW], exp_elem[b]);
        end
        ack_result();
        tests++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || start_cnt - s0 != 1) begin
            fails++;
            $display("FAIL ramp_release: valid=%b in_ready=%b busy=%b starts=%0d required 0 1 0 1",
                     res_valid, in_ready, busy, start_cnt - s0);
        end
    endtask

    task automatic test_clamp_random();
        bit fr;
        int b;
        logic [15:0] sc;
        logic rl;
        rand_frame();
        pix[0] = 16'h0300; pix[1] = 16'hF000; pix[2] = 16'h0080;
        pix[3] = 16'h0100; pix[4] = 16'hFF00; pix[5] = 16'h0101; pix[6] = 16'hFEFF;
        sc = 16'($urandom);
        rl = 1'($urandom);
        feed(N, 1'b1, fr);
        tests++;
        if (disc_start !== 1'b1 || !fr) begin
            fails++;
            $display("FAIL clamp_start: disc_start=%b required 1", disc_start);
        end
        tests++;
        if (flat_input[0*DW +: DW] !== 16'h0100 || flat_input[1*DW +: DW] !== 16'hFF00 ||
            flat_input[2*DW +: DW] !== 16'h0080) begin
            fails++;
            $display("FAIL clamp_elems: %h %h %h required 0100 FF00 0080",
                     flat_input[0*DW +: DW], flat_input[1*DW +: DW], flat_input[2*DW +: DW]);
        end
        b = first_bad();
        tests++;
        if (b != -1) begin
            fails++;
            $display("FAIL clamp_frame: elem %0d is %h required %h", b, flat_input[b*DW +: DW], exp_elem[b]);
        end
        disc_respond($urandom_range(1, 5), sc, rl);
        @(negedge clk);
        exp_cnt++;
        tests++;
        if (res_valid !== 1'b1 || res_score !== sc || res_real !== rl || frame_cnt !== 16'(exp_cnt)) begin
            fails++;
            $display("FAIL clamp_result: valid=%b score=%h real=%b cnt=%0d required 1 %h %b %0d",
                     res_valid, res_score, res_real, frame_cnt, sc, rl, exp_cnt);
        end
        ack_result();
    endtask

    task automatic test_backpressure();
        bit fr;
        int b;
        logic [15:0] sc;
        rand_frame();
        sc = 16'($urandom);
        feed(N, 1'b1, fr);
        disc_respond(2, sc, 1'b0);
        @(negedge clk);
        exp_cnt++;
        for (int c = 0; c < 10; c++) begin
            in_valid   = 1'b1;
            in_data    = 16'($urandom);
            disc_score = 16'($urandom);
            if (c == 3) disc_done = 1'b0;
            tests++;
            if (res_valid !== 1'b1 || res_score !== sc || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold cycle %0d: valid=%b score=%h in_ready=%b required 1 %h 0",
                         c, res_valid, res_score, in_ready, sc);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        b = first_bad();
        tests++;
        if (b != -1) begin
            fails++;
            $display("FAIL bp_frame_ignored_input: elem %0d is %h required %h",
                     b, flat_input[b*DW +: DW], exp_elem[b]);
        end
        ack_result();
        tests++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== 16'(exp_cnt)) begin
            fails++;
            $display("FAIL bp_release: valid=%b in_ready=%b cnt=%0d required 0 1 %0d",
                     res_valid, in_ready, frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_stale_done();
        bit fr;
        rand_frame();
        disc_done  = 1'b1;
        disc_score = 16'hDEAD;
        disc_real  = 1'b0;
        feed(N, 1'b0, fr);
        // now in cycle F (disc_start high)
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 2) disc_done = 1'b0;
            tests++;
            if (res_valid !== 1'b0) begin
                fails++;
                $display("FAIL stale_early_capture at start+%0d: res_valid=%b required 0", k, res_valid);
            end
            if (k == 6) begin
                disc_done  = 1'b1;
                disc_score = 16'h7E57;
                disc_real  = 1'b1;
            end
        end
        @(negedge clk);
        exp_cnt++;
        tests++;
        if (res_valid !== 1'b1 || res_score !== 16'h7E57 || res_real !== 1'b1 || frame_cnt !== 16'(exp_cnt)) begin
            fails++;
            $display("FAIL stale_capture: valid=%b score=%h real=%b cnt=%0d required 1 7E57 1 %0d",
                     res_valid, res_score, res_real, frame_cnt, exp_cnt);
        end
        ack_result();
    endtask

    task automatic test_timeout();
        bit fr;
        int b;
        logic [15:0] sc;
        rand_frame();
        disc_done = 1'b0;
        feed(N, 1'b1, fr);
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk);
            tests++;
            if (timeout_err !== 1'b0 || res_valid !== 1'b0 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL tmo_early at start+%0d: tmo=%b valid=%b in_ready=%b required 0 0 0",
                         k, timeout_err, res_valid, in_ready);
            end
        end
        @(negedge clk);
        tests++;
        if (timeout_err !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 ||
            res_valid !== 1'b0 || frame_cnt !== 16'(exp_cnt)) begin
            fails++;
            $display("FAIL tmo_abort: tmo=%b in_ready=%b busy=%b valid=%b cnt=%0d required 1 1 0 0 %0d",
                     timeout_err, in_ready, busy, res_valid, frame_cnt, exp_cnt);
        end
        // next frame still scores normally; error stays sticky
        rand_frame();
        sc = 16'($urandom);
        feed(N, 1'b1, fr);
        disc_respond(3, sc, 1'b1);
        @(negedge clk);
        exp_cnt++;
        b = first_bad();
        tests++;
        if (res_valid !== 1'b1 || res_score !== sc || frame_cnt !== 16'(exp_cnt) ||
            timeout_err !== 1'b1 || b != -1) begin
            fails++;
            $display("FAIL tmo_recover: valid=%b score=%h cnt=%0d tmo=%b bad=%0d required 1 %h %0d 1 -1",
                     res_valid, res_score, frame_cnt, timeout_err, b, sc, exp_cnt);
        end
        ack_result();
    endtask

    task automatic test_reset_midframe();
        bit fr;
        int s0;
        int b;
        logic [15:0] sc;
        rand_frame();
        feed(100, 1'b1, fr);
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1 || flat_input !== '0 || timeout_err !== 1'b0 ||
            frame_cnt !== 16'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midrst_values: in_ready=%b flat_zero=%b tmo=%b cnt=%0d busy=%b required 1 1 0 0 0",
                     in_ready, flat_input == '0, timeout_err, frame_cnt, busy);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        s0 = start_cnt;
        rand_frame();
        feed(156, 1'b1, fr);
        repeat (2) @(negedge clk);
        tests++;
        if (start_cnt != s0 || busy !== 1'b0 || in_ready !== 1'b1 || fr) begin
            fails++;
            $display("FAIL midrst_no_early_start: starts=%0d busy=%b in_ready=%b required 0 0 1",
                     start_cnt - s0, busy, in_ready);
        end
        feed(100, 1'b1, fr);
        tests++;
        if (disc_start !== 1'b1 || !fr) begin
            fails++;
            $display("FAIL midrst_start_at_256: disc_start=%b required 1", disc_start);
        end
        sc = 16'($urandom);
        disc_respond(2, sc, 1'b0);
        @(negedge clk);
        exp_cnt++;
        b = first_bad();
        tests++;
        if (res_valid !== 1'b1 || res_score !== sc || frame_cnt !== 16'(exp_cnt) || b != -1) begin
            fails++;
            $display("FAIL midrst_result: valid=%b score=%h cnt=%0d bad=%0d required 1 %h %0d -1",
                     res_valid, res_score, frame_cnt, b, sc, exp_cnt);
        end
        ack_result();
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_clamp_random();
        test_backpressure();
        test_stale_done();
        test_timeout();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
